// File: rtl/panel_pkg.sv
// Shared operator-panel types and default 10 kHz button timing constants.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } btn_state_t;

  // 0.5 s hold before auto-repeat, then 100 ms between repeats, at 10 kHz.
  localparam int HOLD_DLY_10K = 5000;
  localparam int RPT_PER_10K  = 1000;

endpackage

// File: rtl/btn_hold_timer.sv
// Hold/repeat counter for the button stepper: clear has priority over enable,
// and the compare outputs flag the hold delay and repeat period end points.
module btn_hold_timer #(
  parameter int CNT_BITS = 13,
  parameter int HOLD_DLY = panel_pkg::HOLD_DLY_10K,
  parameter int RPT_PER  = panel_pkg::RPT_PER_10K
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hold_done,
  output logic rpt_done
);

  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hold_done = (cnt == CNT_BITS'(HOLD_DLY - 1));
  assign rpt_done  = (cnt == CNT_BITS'(RPT_PER - 1));

endmodule

// File: rtl/button_index_step.sv
// Debounced up/down buttons to index steps with hold-to-repeat.
// BUTTON_INDEX_WRAP_EN selects wrap-around at the ends; default saturates.
module button_index_step
  import panel_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int IDX_MAX  = 99,
  parameter int HOLD_DLY = HOLD_DLY_10K,
  parameter int RPT_PER  = RPT_PER_10K,
  parameter int CNT_BITS = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_dn,
  output logic [IDX_BITS-1:0] index,
  output logic                step,
  output logic                dir,
  output logic                repeating
);

  btn_state_t state, state_n;
  logic       up_q, dn_q;
  logic       active, active_n;   // 1 = up button owns the hold
  logic       cnt_clr, cnt_en;
  logic       hold_done, rpt_done;
  logic       step_req, step_up;
  logic       up_press, dn_press;
  logic       act_lvl, oth_lvl;
  logic       at_lim, moved;
  logic [IDX_BITS-1:0] idx_n;

  btn_hold_timer #(
    .CNT_BITS (CNT_BITS),
    .HOLD_DLY (HOLD_DLY),
    .RPT_PER  (RPT_PER)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .hold_done (hold_done),
    .rpt_done  (rpt_done)
  );

  assign up_press = btn_up & ~up_q;
  assign dn_press = btn_dn & ~dn_q;
  assign act_lvl  = active ? btn_up : btn_dn;
  assign oth_lvl  = active ? btn_dn : btn_up;

  always_comb begin
    state_n  = state;
    active_n = active;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    step_req = 1'b0;
    step_up  = active;
    unique case (state)
      IDLE: begin
        if (btn_up && btn_dn) begin
          state_n = LOCK;
        end else if (up_press || dn_press) begin
          state_n  = HOLD;
          active_n = up_press;
          step_up  = up_press;
          step_req = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      HOLD, REPEAT: begin
        // Release wins over a simultaneous press of the other button.
        if (!act_lvl) begin
          state_n = IDLE;
        end else if (oth_lvl) begin
          state_n = LOCK;
        end else if ((state == HOLD) ? hold_done : rpt_done) begin
          state_n  = REPEAT;
          step_req = 1'b1;
          cnt_clr  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      LOCK: begin
        if (!btn_up && !btn_dn) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    at_lim = step_up ? (index == IDX_BITS'(IDX_MAX)) : (index == '0);
`ifdef BUTTON_INDEX_WRAP_EN
    moved = 1'b1;
    if (step_up) idx_n = at_lim ? '0 : index + 1'b1;
    else         idx_n = at_lim ? IDX_BITS'(IDX_MAX) : index - 1'b1;
`else
    moved = ~at_lim;
    if (at_lim)       idx_n = index;
    else if (step_up) idx_n = index + 1'b1;
    else              idx_n = index - 1'b1;
`endif
  end

  // Edge-detect copies track the inputs through reset so a held button is not a press.
  always_ff @(posedge clk) begin
    up_q <= btn_up;
    dn_q <= btn_dn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      active <= 1'b1;
      index  <= '0;
      step   <= 1'b0;
      dir    <= 1'b1;
    end else begin
      state  <= state_n;
      active <= active_n;
      step   <= step_req & moved;
      if (step_req) begin
        dir <= step_up;
        if (moved) index <= idx_n;
      end
    end
  end

  assign repeating = (state == REPEAT);

endmodule

// File: tb/tb_button_index_step.sv
// Directed bench for button_index_step with IDX_MAX=9, HOLD_DLY=4, RPT_PER=2.
// Define BUTTON_INDEX_WRAP_EN on both DUT and bench to check the wrap build.
module tb_button_index_step;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_dn;
  logic [7:0] index;
  logic       step, dir, repeating;

  int n_checks = 0;
  int n_fail   = 0;

  button_index_step #(
    .IDX_BITS (8),
    .IDX_MAX  (9),
    .HOLD_DLY (4),
    .RPT_PER  (2),
    .CNT_BITS (13)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .index     (index),
    .step      (step),
    .dir       (dir),
    .repeating (repeating)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int steps;
  int smask, rmask;

  initial begin
    reset  = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();
    tick();
    check("rst_index", index, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 1);
    check("rst_rep", repeating, 0);
    reset = 1'b0;
    tick();

    // Single tap: two cycles high
    btn_up = 1'b1;
    tick();
    check("tap_step", step, 1);
    check("tap_index", index, 1);
    check("tap_dir", dir, 1);
    tick();
    check("tap_step_once", step, 0);
    btn_up = 1'b0;
    steps = 0; rmask = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      steps += step;
      rmask |= repeating;
    end
    check("tap_no_more_steps", steps, 0);
    check("tap_never_rep", rmask, 0);
    check("tap_index_after", index, 1);

    // Hold for 12 cycles: steps at ticks 0,4,6,8,10; repeating on ticks 4..11
    btn_up = 1'b1;
    smask = 0; rmask = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (step) smask |= (1 << k);
      if (repeating) rmask |= (1 << k);
    end
    btn_up = 1'b0;
    check("hold_step_pattern", smask, 32'h551);
    check("hold_rep_pattern", rmask, 32'hFF0);
    check("hold_index", index, 6);
    tick();
    check("hold_rep_fall", repeating, 0);
    check("hold_no_step_release", step, 0);

    // Down held, then up joins mid-hold: lock out
    btn_dn = 1'b1;
    tick();
    check("dn_step", step, 1);
    check("dn_index", index, 5);
    check("dn_dir", dir, 0);
    tick();
    tick();
    btn_up = 1'b1;
    steps = 0; rmask = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      steps += step;
      rmask |= repeating;
    end
    check("lock_no_steps", steps, 0);
    check("lock_no_rep", rmask, 0);
    check("lock_index", index, 5);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();
    tick();
    btn_up = 1'b1;
    tick();
    check("post_lock_step", step, 1);
    check("post_lock_index", index, 6);
    check("post_lock_dir", dir, 1);
    btn_up = 1'b0;
    steps = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      steps += step;
    end
    check("post_lock_one_step", steps, 0);

    // Reset during REPEAT with button still held
    btn_up = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_rep", repeating, 1);
    check("pre_rst_index", index, 8);
    reset = 1'b1;
    tick();
    check("mid_rst_index", index, 0);
    check("mid_rst_step", step, 0);
    check("mid_rst_dir", dir, 1);
    check("mid_rst_rep", repeating, 0);
    reset = 1'b0;
    steps = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      steps += step;
    end
    check("held_thru_rst_no_step", steps, 0);
    check("held_thru_rst_index", index, 0);
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    check("repress_step", step, 1);
    check("repress_index", index, 1);
    btn_up = 1'b0;
    tick();
    tick();

    // Back down to 0, then tap down at the lower end
    btn_dn = 1'b1;
    tick();
    check("to_zero_index", index, 0);
    btn_dn = 1'b0;
    tick();
    tick();
    btn_dn = 1'b1;
    tick();
`ifdef BUTTON_INDEX_WRAP_EN
    check("wrap_step", step, 1);
    check("wrap_index", index, 9);
`else
    check("sat_step", step, 0);
    check("sat_index", index, 0);
`endif
    btn_dn = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
